// File: rtl/lsu_byte_seq.sv
// Byte-serialising load/store unit: one core request becomes 1/2/4 single-byte ram beats.
// Optional macro LSU_MISALIGNED_EN: misaligned half/word accesses run as byte beats instead of faulting.
module lsu_byte_seq #(
  parameter int ram_width = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic        mem_rw,
  output logic [1:0]  mem_len,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write,
  input  logic [31:0] mem_read,
  input  logic        mem_exception
);

  typedef enum logic [1:0] {IDLE = 2'd0, BEAT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_r;
  logic        we_r;
  logic [1:0]  size_r;
  logic        uns_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] ldata_r;
  logic [1:0]  cnt_r;

  logic [2:0]  req_beats_s;
  logic [32:0] last_byte_s;
  logic        misaligned_s;
  logic        req_exc_s;
  logic [31:0] ldata_s;
  logic        last_s;
  logic        unused_s;

  function automatic logic [31:0] extend(input logic [1:0] size, input logic uns, input logic [31:0] d);
    case (size)
      2'b00:   extend = {{24{d[7] & ~uns}}, d[7:0]};
      2'b01:   extend = {{16{d[15] & ~uns}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] idx);
    return d[{idx, 3'b000} +: 8];
  endfunction

  assign mem_len  = 2'b00;
  assign unused_s = ^mem_read[31:8];

  // Request fault check: illegal size, misalignment, or last byte beyond the ram.
  always_comb begin
    req_beats_s = 3'd1 << req_size;
    last_byte_s = {1'b0, req_addr} + {30'd0, req_beats_s} - 33'd1;
`ifdef LSU_MISALIGNED_EN
    misaligned_s = 1'b0;
`else
    misaligned_s = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    req_exc_s = (req_size == 2'b11) || misaligned_s ||
                (last_byte_s >= (33'd1 << ram_width));
  end

  // Merge the current beat's read byte into its lane and detect the final beat.
  always_comb begin
    ldata_s = ldata_r;
    ldata_s[{cnt_r, 3'b000} +: 8] = mem_read[7:0];
    last_s = ({1'b0, cnt_r} == ((3'd1 << size_r) - 3'd1));
  end

  // Sequencer FSM with registered response and ram-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      we_r       <= 1'b0;
      size_r     <= 2'b00;
      uns_r      <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      ldata_r    <= 32'd0;
      cnt_r      <= 2'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_exc   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_rw     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_write  <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            we_r       <= req_we;
            size_r     <= req_size;
            uns_r      <= req_unsigned;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
            ldata_r    <= 32'd0;
            cnt_r      <= 2'd0;
            req_ready  <= 1'b0;
            resp_rdata <= 32'd0;
            if (req_exc_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_exc   <= 1'b1;
            end else begin
              state_r    <= BEAT;
              resp_exc   <= 1'b0;
              mem_rw     <= req_we;
              mem_addr   <= req_addr;
              mem_write  <= {24'd0, req_wdata[7:0]};
            end
          end
        end
        BEAT: begin
          ldata_r <= ldata_s;
          if (mem_exception || last_s) begin
            state_r    <= RESP;
            resp_valid <= 1'b1;
            resp_exc   <= mem_exception;
            resp_rdata <= (mem_exception || we_r) ? 32'd0 : extend(size_r, uns_r, ldata_s);
            mem_rw     <= 1'b0;
            mem_addr   <= 32'd0;
            mem_write  <= 32'd0;
          end else begin
            cnt_r     <= cnt_r + 2'd1;
            mem_addr  <= addr_r + {30'd0, cnt_r + 2'd1};
            mem_write <= {24'd0, byte_sel(wdata_r, cnt_r + 2'd1)};
          end
        end
        RESP: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_exc   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_exc   <= 1'b0;
          mem_rw     <= 1'b0;
          mem_addr   <= 32'd0;
          mem_write  <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Randomised bench for lsu_byte_seq: a byte-array ram plus a request-level reference model.
module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic        mem_rw;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_write;
  logic [31:0] mem_read;
  logic        mem_exception = 1'b0;

  logic [7:0] ram [0:4095];
  logic [7:0] model_mem [0:4095];
  int n_chk = 0;
  int n_fail = 0;

  lsu_byte_seq #(.ram_width(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .mem_rw(mem_rw), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_read(mem_read), .mem_exception(mem_exception)
  );

  always #5 clk = ~clk;

  // Byte ram: combinational read with junk in the unused upper bits, write on rising edge.
  always_comb mem_read = {24'h5A3C96, ram[mem_addr[11:0]]};
  always @(posedge clk) if (mem_rw && !mem_exception) ram[mem_addr[11:0]] <= mem_write[7:0];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete request: reference expectation, drive, beat-by-beat monitor, response check.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input int fault);
    int n, beats_e, nb, lat, guard, stored;
    logic exc_e;
    logic mis;
    logic [31:0] rd_e;
    longint v, last;
    n = (size == 2'b11) ? 0 : (1 << size);
`ifdef LSU_MISALIGNED_EN
    mis = 1'b0;
`else
    mis = (n != 0) && ((addr % n) != 0);
`endif
    last = longint'(addr) + n - 1;
    exc_e = (n == 0) || mis || (last >= 4096);
    beats_e = exc_e ? 0 : n;
    if (!exc_e && fault >= 0 && fault < n) begin
      beats_e = fault + 1;
      exc_e = 1'b1;
    end
    rd_e = 32'd0;
    if (!exc_e && !we) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(model_mem[addr + i]) << (8 * i));
      if (!uns && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
      rd_e = v[31:0];
    end
    if (we && beats_e > 0) begin
      stored = (exc_e) ? beats_e - 1 : beats_e;
      for (int i = 0; i < stored; i++) model_mem[addr + i] = wdata[8 * i +: 8];
    end

    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val("ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom; req_size = $urandom; req_unsigned = $urandom;
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    nb = 0;
    while (!resp_valid && lat < 12) begin
      if (!req_ready) begin
        check_val("beat_addr", mem_addr, addr + nb);
        check_val("beat_rw", {31'd0, mem_rw}, {31'd0, we});
        check_val("beat_wdata", mem_write, {24'd0, wdata[8 * nb +: 8]});
        mem_exception = (nb == fault);
        nb++;
      end
      @(negedge clk);
      mem_exception = 1'b0;
      lat++;
    end
    check_val("resp_valid", {31'd0, resp_valid}, 32'd1);
    check_val("latency", lat, beats_e + 1);
    check_val("beats", nb, beats_e);
    check_val("resp_exc", {31'd0, resp_exc}, {31'd0, exc_e});
    check_val("resp_rdata", resp_rdata, rd_e);
    check_val("idle_mem", {mem_rw, mem_addr[30:0]} | mem_write, 32'd0);
    @(negedge clk);
    check_val("resp_pulse", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int r, flt;
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 8'($urandom);
      model_mem[i] = ram[i];
    end
    #12;
    check_val("rst_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp", {30'd0, resp_valid, resp_exc}, 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_mem", {29'd0, mem_rw, mem_len}, 32'd0);
    check_val("rst_maddr", mem_addr, 32'd0);
    check_val("rst_mwrite", mem_write, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, -1);
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, -1);
    run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, -1);
    run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, -1);
    run_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, -1);
    run_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, -1);
    run_req(1'b0, 2'b10, 1'b0, 32'hFFE, 32'h0, -1);
    run_req(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, -1);
    run_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, -1);
    run_req(1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0, -1);
    run_req(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 1);
    run_req(1'b0, 2'b10, 1'b1, 32'h200, 32'h0, -1);

    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 15);
      sz = (r == 0) ? 2'b11 : 2'(r % 3);
      r = $urandom_range(0, 9);
      if (r == 0) a = 32'hFFFFFFFF - $urandom_range(0, 7);
      else if (r == 1) a = 32'hFF8 + $urandom_range(0, 7);
      else a = $urandom_range(0, 511);
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      flt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_req(1'($urandom), sz, 1'($urandom), a, $urandom, flt);
    end

    // Reset in the middle of a word store must drop the ram port immediately and for good.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    check_val("mid_rw", {31'd0, mem_rw}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_rw", {31'd0, mem_rw}, 32'd0);
    check_val("arst_addr", mem_addr, 32'd0);
    check_val("arst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("post_rst", {30'd0, mem_rw, resp_valid}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
